// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder definitions: default trellis/survivor sizes, index types
// and the traceback controller state encoding.
package viterbi_pkg;

  localparam int K_DEF  = 5;
  localparam int M_DEF  = K_DEF - 1;
  localparam int S_DEF  = 1 << M_DEF;
  localparam int D_DEF  = 10;
  localparam int TW_DEF = (D_DEF > 1) ? $clog2(D_DEF) : 1;

  typedef logic [M_DEF-1:0]  state_idx_t;
  typedef logic [TW_DEF-1:0] time_idx_t;

  // Predecessor convention shared with the ACS and survivor_mem:
  // pred = {surv_bit, s[M-1:1]}.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    OUT   = 2'd2
  } tb_state_t;

endpackage

// File: rtl/traceback_ctrl.sv
// Survivor memory scheduler: writes ACS rows, traces back D rows from the best
// state once the memory is full, and hands one decoded bit downstream per row.
module traceback_ctrl
  import viterbi_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int M = K - 1,
  parameter int S = 1 << M,
  parameter int D = D_DEF,
  localparam int TW = (D > 1) ? $clog2(D) : 1,
  localparam int FW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          row_valid,
  output logic          row_ready,
  input  logic [S-1:0]  surv_row,
  input  logic [M-1:0]  best_state,
  output logic          mem_wr_en,
  output logic [S-1:0]  mem_row,
  input  logic [TW-1:0] mem_wr_ptr,
  output logic [M-1:0]  rd_state,
  output logic [TW-1:0] rd_time,
  input  logic          surv_bit,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic          dec_bit,
  output logic          busy
);

  localparam logic [TW-1:0] LAST_IDX = TW'(D - 1);
  localparam logic [FW-1:0] FULL_CNT = FW'(D);

  tb_state_t     state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [FW-1:0] fill_inc;
  logic [TW-1:0] t_q, t_d;
  logic [TW-1:0] k_q, k_d;
  logic [M-1:0]  s_q, s_d;
  logic          dec_bit_q, dec_bit_d;
  logic          accept;

  // row_ready stays low while rst is asserted so nothing is accepted in reset.
  assign row_ready = (state_q == IDLE) && !rst;
  assign accept    = row_valid && row_ready;
  assign mem_wr_en = accept;
  assign mem_row   = surv_row;
  assign fill_inc  = (fill_q == FULL_CNT) ? fill_q : fill_q + 1'b1;

  assign rd_state  = s_q;
  assign rd_time   = t_q;
  assign dec_valid = (state_q == OUT);
  assign dec_bit   = dec_bit_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    t_d       = t_q;
    k_d       = k_q;
    s_d       = s_q;
    dec_bit_d = dec_bit_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          fill_d = fill_inc;
          if (fill_inc == FULL_CNT) begin
            t_d     = mem_wr_ptr;
            s_d     = best_state;
            k_d     = '0;
            state_d = TRACE;
          end
        end
      end

      TRACE: begin
        s_d = {surv_bit, s_q[M-1:1]};
        t_d = (t_q == '0) ? LAST_IDX : t_q - 1'b1;
        k_d = k_q + 1'b1;
        // The oldest row's state LSB is the decoded bit, taken before the final step.
        if (k_q == LAST_IDX) begin
          dec_bit_d = s_q[0];
          state_d   = OUT;
        end
      end

      OUT: begin
        if (dec_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      t_q       <= '0;
      k_q       <= '0;
      s_q       <= '0;
      dec_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      t_q       <= t_d;
      k_q       <= k_d;
      s_q       <= s_d;
      dec_bit_q <= dec_bit_d;
    end
  end

endmodule
